// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for the pipeline stage register: upstream in_* side and downstream out_* side.
// master is the side that drives the stage's inputs; slave is the stage itself.
interface pipe_stage_reg_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [AW-1:0] in_pcp2;
  logic [DW-1:0] in_ir;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pcp2;
  logic [DW-1:0] out_ir;

  modport master (
    output in_valid, in_pc, in_pcp2, in_ir, out_ready,
    input  in_ready, out_valid, out_pc, out_pcp2, out_ir
  );

  modport slave (
    input  in_valid, in_pc, in_pcp2, in_ir, out_ready,
    output in_ready, out_valid, out_pc, out_pcp2, out_ir
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register carrying {pc, pcp2, ir}, with flush and a
// saturating backpressure counter. in_ready depends only on registered state.
module pipe_stage_reg #(
  parameter int            AW  = 16,
  parameter int            DW  = 16,
  parameter logic [DW-1:0] NOP = '0
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                flush,
  pipe_stage_reg_if.slave     bus,
  output logic [15:0]         stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mPc_q, mPc_d, mPcp2_q, mPcp2_d;
  logic [DW-1:0] mIr_q, mIr_d;
  logic [AW-1:0] sPc_q, sPc_d, sPcp2_q, sPcp2_d;
  logic [DW-1:0] sIr_q, sIr_d;
  logic [15:0]   stallCnt_q, stallCnt_d;

  logic mValid, sValid, accept, drain;

  assign mValid = (state_q != EMPTY);
  assign sValid = (state_q == FULL);
  assign accept = bus.in_valid & ~sValid;
  assign drain  = mValid & bus.out_ready;

  assign bus.in_ready  = ~sValid;
  assign bus.out_valid = mValid;
  assign bus.out_pc    = mValid ? mPc_q   : '0;
  assign bus.out_pcp2  = mValid ? mPcp2_q : '0;
  assign bus.out_ir    = mValid ? mIr_q   : NOP;
  assign stall_cnt     = stallCnt_q;

  always_comb begin
    state_d    = state_q;
    mPc_d      = mPc_q;
    mPcp2_d    = mPcp2_q;
    mIr_d      = mIr_q;
    sPc_d      = sPc_q;
    sPcp2_d    = sPcp2_q;
    sIr_d      = sIr_q;
    stallCnt_d = stallCnt_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          mPc_d   = bus.in_pc;
          mPcp2_d = bus.in_pcp2;
          mIr_d   = bus.in_ir;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          mPc_d   = bus.in_pc;
          mPcp2_d = bus.in_pcp2;
          mIr_d   = bus.in_ir;
        end else if (accept) begin
          sPc_d   = bus.in_pc;
          sPcp2_d = bus.in_pcp2;
          sIr_d   = bus.in_ir;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          mPc_d   = sPc_q;
          mPcp2_d = sPcp2_q;
          mIr_d   = sIr_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush only drops the valid bits; stale fields are masked at the outputs.
    if (flush) begin
      state_d = EMPTY;
    end

    if (mValid && !bus.out_ready && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_d = stallCnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= EMPTY;
      mPc_q      <= '0;
      mPcp2_q    <= '0;
      mIr_q      <= '0;
      sPc_q      <= '0;
      sPcp2_q    <= '0;
      sIr_q      <= '0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mPc_q      <= mPc_d;
      mPcp2_q    <= mPcp2_d;
      mIr_q      <= mIr_d;
      sPc_q      <= sPc_d;
      sPcp2_q    <= sPcp2_d;
      sIr_q      <= sIr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a two-slot FIFO queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_stage_reg;

  localparam int            AW     = 16;
  localparam int            DW     = 16;
  localparam logic [DW-1:0] TB_NOP = 16'h4E71;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        flush;
  logic [15:0] stall_cnt;

  pipe_stage_reg_if #(.AW(AW), .DW(DW)) bus ();

  pipe_stage_reg #(.AW(AW), .DW(DW), .NOP(TB_NOP)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .flush     (flush),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pcp2;
    logic [DW-1:0] ir;
  } entry_t;

  entry_t modelQ[$];
  int     modelStall;
  int     cmpCount = 0;
  int     errCount = 0;
  bit     drainM, acceptM;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic          expValid;
    logic [AW-1:0] expPc, expPcp2;
    logic [DW-1:0] expIr;
    expValid = (modelQ.size() > 0);
    expPc    = expValid ? modelQ[0].pc   : '0;
    expPcp2  = expValid ? modelQ[0].pcp2 : '0;
    expIr    = expValid ? modelQ[0].ir   : TB_NOP;
    cmp("in_ready",  32'(bus.in_ready),  32'(modelQ.size() < 2));
    cmp("out_valid", 32'(bus.out_valid), 32'(expValid));
    cmp("out_pc",    32'(bus.out_pc),    32'(expPc));
    cmp("out_pcp2",  32'(bus.out_pcp2),  32'(expPcp2));
    cmp("out_ir",    32'(bus.out_ir),    32'(expIr));
    cmp("stall_cnt", 32'(stall_cnt),     32'(modelStall));
  endtask

  // Reference: the stage behaves as a 2-deep FIFO whose accept/drain/stall decisions use
  // the occupancy seen before the edge.
  always @(posedge CLK) begin
    if (Reset) begin
      modelQ.delete();
      modelStall = 0;
    end else begin
      drainM  = (modelQ.size() > 0) && bus.out_ready;
      acceptM = bus.in_valid && (modelQ.size() < 2);
      if ((modelQ.size() > 0) && !bus.out_ready && (modelStall < 65535)) modelStall++;
      if (flush) begin
        modelQ.delete();
      end else begin
        if (drainM) void'(modelQ.pop_front());
        if (acceptM) modelQ.push_back('{pc: bus.in_pc, pcp2: bus.in_pcp2, ir: bus.in_ir});
      end
    end
    #1;
    checkOutput();
  end

  task automatic applyStimulus(input logic rst, input logic fl, input logic vld,
                               input logic [AW-1:0] pc, input logic [DW-1:0] ir,
                               input logic ordy);
    Reset         = rst;
    flush         = fl;
    bus.in_valid  = vld;
    bus.in_pc     = pc;
    bus.in_pcp2   = pc + 16'd2;
    bus.in_ir     = ir;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    cmp("rst_in_ready",  32'(bus.in_ready),  32'd1);
    cmp("rst_out_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst_out_ir",    32'(bus.out_ir),    32'h4E71);
    cmp("rst_stall",     32'(stall_cnt),     32'd0);

    // First entry latency, then an 8-entry back-to-back stream.
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010, 16'hABCD, 1'b1);
    tick();
    cmp("first_valid", 32'(bus.out_valid), 32'd1);
    cmp("first_pc",    32'(bus.out_pc),    32'h0010);
    cmp("first_pcp2",  32'(bus.out_pcp2),  32'h0012);
    cmp("first_ir",    32'(bus.out_ir),    32'hABCD);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h0100 + 4 * i), 16'(16'h5000 + i), 1'b1);
      tick();
      cmp("stream_pc", 32'(bus.out_pc), 32'(16'h0100 + 4 * i));
      cmp("stream_ir", 32'(bus.out_ir), 32'(16'h5000 + i));
    end

    // Backpressure into FULL, then drain A then B.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0A00, 16'h000A, 1'b0);
    tick();
    cmp("bp_A_pc",    32'(bus.out_pc),   32'h0A00);
    cmp("bp_A_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0B00, 16'h000B, 1'b0);
    tick();
    cmp("bp_full_ready", 32'(bus.in_ready), 32'd0);
    cmp("bp_full_pc",    32'(bus.out_pc),   32'h0A00);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cmp("drain_A_ir", 32'(bus.out_ir), 32'h000A);
    tick();
    cmp("drain_B_ir", 32'(bus.out_ir), 32'h000B);
    cmp("drain_B_pc", 32'(bus.out_pc), 32'h0B00);
    tick();
    cmp("drain_empty", 32'(bus.out_valid), 32'd0);

    // Flush from FULL with a simultaneous input.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0A00, 16'h000A, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0B00, 16'h000B, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0C00, 16'h000C, 1'b0);
    tick();
    cmp("flush_valid", 32'(bus.out_valid), 32'd0);
    cmp("flush_ir",    32'(bus.out_ir),    32'h4E71);
    cmp("flush_ready", 32'(bus.in_ready),  32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    repeat (3) tick();
    cmp("flush_gone", 32'(bus.out_valid), 32'd0);

    // Stall counting and saturation.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0D00, 16'h000D, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    repeat (5) tick();
    cmp("stall_5", 32'(stall_cnt), 32'd5);
    repeat (70000) tick();
    cmp("stall_sat", 32'(stall_cnt), 32'h0000FFFF);

    // Reset in FULL with stall_cnt=3 overrides flush/accept.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0A00, 16'h000A, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0B00, 16'h000B, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    cmp("pre_rst_stall", 32'(stall_cnt),    32'd3);
    cmp("pre_rst_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0E00, 16'h000E, 1'b1);
    tick();
    cmp("rst2_ready", 32'(bus.in_ready),  32'd1);
    cmp("rst2_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst2_pc",    32'(bus.out_pc),    32'd0);
    cmp("rst2_pcp2",  32'(bus.out_pcp2),  32'd0);
    cmp("rst2_ir",    32'(bus.out_ir),    32'h4E71);
    cmp("rst2_stall", 32'(stall_cnt),     32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 60) == 0, ($urandom % 20) == 0, ($urandom % 10) < 7,
                    16'($urandom), 16'($urandom), ($urandom % 10) < 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
